reg_file_sb: RTL and testbench

- Parametrised general-purpose register file with a per-register pending-write scoreboard. Successor to the per-register load-enabled GP registers.
- Replaces the discrete R0..Rn registers and the source mux that drives the ALU/bus.
- Provides one write port, two combinational read ports with optional write-through bypass, and reservation/clear tracking so the controller can stall on read-after-write hazards.

---
 rtl/reg_file_sb_pkg.sv | 11 +
 rtl/reg_file_sb_rd_port.sv | 37 +++
 rtl/reg_file_sb.sv | 79 +++++++
 tb/tb_reg_file_sb.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_file_sb_pkg.sv
// Shared constants and index type for the scoreboarded register file, so controller
// and datapath code can size their register indices consistently.
package reg_file_sb_pkg;

    localparam int WORD_SIZE_DEF = 8;
    localparam int NUM_REGS_DEF  = 4;
    localparam int ADDR_W_DEF    = $clog2(NUM_REGS_DEF);

    typedef logic [ADDR_W_DEF-1:0] reg_idx_t;

endpackage

// File: rtl/reg_file_sb_rd_port.sv
// One combinational read port: register select, optional same-cycle write forwarding,
// and the ready flag derived from the scoreboard.
module reg_file_rd_port
    import reg_file_sb_pkg::*;
#(
    parameter int WORD_SIZE = WORD_SIZE_DEF,
    parameter int NUM_REGS  = NUM_REGS_DEF,
    parameter int BYPASS    = 1,
    parameter int ADDR_W    = $clog2(NUM_REGS)
) (
    input  logic [ADDR_W-1:0]    rd_addr,
    input  logic [WORD_SIZE-1:0] regs [NUM_REGS],
    input  logic [NUM_REGS-1:0]  pending,
    input  logic                 wr_en,
    input  logic [ADDR_W-1:0]    wr_addr,
    input  logic [WORD_SIZE-1:0] wr_data,
    output logic [WORD_SIZE-1:0] rd_data,
    output logic                 rd_ready
);

    // Defaults cover indices past the last register: data 0, always ready.
    always_comb begin
        rd_data  = '0;
        rd_ready = 1'b1;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (rd_addr == ADDR_W'(i)) begin
                rd_data  = regs[i];
                rd_ready = !pending[i];
                if (BYPASS != 0 && wr_en && wr_addr == rd_addr) begin
                    rd_data  = wr_data;
                    rd_ready = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/reg_file_sb.sv
// General-purpose register file with one write port, two read ports and a
// pending-write scoreboard used by the controller to stall on RAW hazards.
module reg_file_sb
    import reg_file_sb_pkg::*;
#(
    parameter int WORD_SIZE = WORD_SIZE_DEF,
    parameter int NUM_REGS  = NUM_REGS_DEF,
    parameter int BYPASS    = 1,
    localparam int ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en,
    input  logic [ADDR_W-1:0]    wr_addr,
    input  logic [WORD_SIZE-1:0] wr_data,
    input  logic [ADDR_W-1:0]    rd_addr_a,
    output logic [WORD_SIZE-1:0] rd_data_a,
    output logic                 rd_ready_a,
    input  logic [ADDR_W-1:0]    rd_addr_b,
    output logic [WORD_SIZE-1:0] rd_data_b,
    output logic                 rd_ready_b,
    input  logic                 rsv_en,
    input  logic [ADDR_W-1:0]    rsv_addr,
    output logic [NUM_REGS-1:0]  pending
);

    logic [WORD_SIZE-1:0] regs_q [NUM_REGS];
    logic [WORD_SIZE-1:0] regs_d [NUM_REGS];
    logic [NUM_REGS-1:0]  pending_q;
    logic [NUM_REGS-1:0]  pending_d;
    logic                 fwd_en;

    // Per-register compare against the loop index keeps out-of-range writes and
    // reservations from touching anything; a reservation wins over a same-cycle clear.
    always_comb begin
        pending_d = pending_q;
        for (int i = 0; i < NUM_REGS; i++) begin
            regs_d[i] = regs_q[i];
            if (wr_en && wr_addr == ADDR_W'(i)) begin
                regs_d[i]    = wr_data;
                pending_d[i] = 1'b0;
            end
            if (rsv_en && rsv_addr == ADDR_W'(i)) begin
                pending_d[i] = 1'b1;
            end
        end
    end

    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                regs_q[gi]    <= '0;
                pending_q[gi] <= 1'b0;
            end else begin
                regs_q[gi]    <= regs_d[gi];
                pending_q[gi] <= pending_d[gi];
            end
        end
    end

    // While reset is held the write is discarded, so it must not forward either.
    assign fwd_en  = wr_en & rst;
    assign pending = pending_q;

    reg_file_rd_port #(
        .WORD_SIZE(WORD_SIZE), .NUM_REGS(NUM_REGS), .BYPASS(BYPASS), .ADDR_W(ADDR_W)
    ) u_rd_a (
        .rd_addr(rd_addr_a), .regs(regs_q), .pending(pending_q), .wr_en(fwd_en),
        .wr_addr(wr_addr), .wr_data(wr_data), .rd_data(rd_data_a), .rd_ready(rd_ready_a)
    );

    reg_file_rd_port #(
        .WORD_SIZE(WORD_SIZE), .NUM_REGS(NUM_REGS), .BYPASS(BYPASS), .ADDR_W(ADDR_W)
    ) u_rd_b (
        .rd_addr(rd_addr_b), .regs(regs_q), .pending(pending_q), .wr_en(fwd_en),
        .wr_addr(wr_addr), .wr_data(wr_data), .rd_data(rd_data_b), .rd_ready(rd_ready_b)
    );

endmodule

// File: tb/tb_reg_file_sb.sv
// Bench for reg_file_sb: three builds (4 regs bypass, 4 regs no bypass, 6 regs bypass)
// driven from shared stimulus and checked against a behavioural register/scoreboard model.
module tb_reg_file_sb;

    logic       clk;
    logic       rst;
    logic       wr_en;
    logic [2:0] wr_addr;
    logic [7:0] wr_data;
    logic       rsv_en;
    logic [2:0] rsv_addr;
    logic [2:0] rd_addr_a;
    logic [2:0] rd_addr_b;

    logic [7:0] da0, db0, da1, db1, da2, db2;
    logic       ya0, yb0, ya1, yb1, ya2, yb2;
    logic [3:0] p0, p1;
    logic [5:0] p2;

    logic [7:0] da [3];
    logic [7:0] db [3];
    logic       ya [3];
    logic       yb [3];
    logic [7:0] po [3];

    int total_checks;
    int pass_checks;

    // Reference model state, one slot per DUT build.
    logic [7:0] m_mem  [3][8];
    logic       m_pend [3][8];
    int         m_n    [3] = '{4, 4, 6};
    bit         m_byp  [3] = '{1'b1, 1'b0, 1'b1};

    reg_file_sb #(.WORD_SIZE(8), .NUM_REGS(4), .BYPASS(1)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr[1:0]), .wr_data(wr_data),
        .rd_addr_a(rd_addr_a[1:0]), .rd_data_a(da0), .rd_ready_a(ya0),
        .rd_addr_b(rd_addr_b[1:0]), .rd_data_b(db0), .rd_ready_b(yb0),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr[1:0]), .pending(p0)
    );

    reg_file_sb #(.WORD_SIZE(8), .NUM_REGS(4), .BYPASS(0)) dut_nb (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr[1:0]), .wr_data(wr_data),
        .rd_addr_a(rd_addr_a[1:0]), .rd_data_a(da1), .rd_ready_a(ya1),
        .rd_addr_b(rd_addr_b[1:0]), .rd_data_b(db1), .rd_ready_b(yb1),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr[1:0]), .pending(p1)
    );

    reg_file_sb #(.WORD_SIZE(8), .NUM_REGS(6), .BYPASS(1)) dut6 (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr_a(rd_addr_a), .rd_data_a(da2), .rd_ready_a(ya2),
        .rd_addr_b(rd_addr_b), .rd_data_b(db2), .rd_ready_b(yb2),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .pending(p2)
    );

    assign da[0] = da0;  assign db[0] = db0;  assign ya[0] = ya0;  assign yb[0] = yb0;
    assign da[1] = da1;  assign db[1] = db1;  assign ya[1] = ya1;  assign yb[1] = yb1;
    assign da[2] = da2;  assign db[2] = db2;  assign ya[2] = ya2;  assign yb[2] = yb2;
    assign po[0] = {4'b0, p0};
    assign po[1] = {4'b0, p1};
    assign po[2] = {2'b0, p2};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        total_checks++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else
            pass_checks++;
    endtask

    function automatic int eff_addr(input int k, input logic [2:0] a);
        return (k < 2) ? int'(a[1:0]) : int'(a);
    endfunction

    // Expected read result from the architectural rules.
    task automatic model_read(input int k, input logic [2:0] a_raw,
                              output logic [7:0] d, output logic y);
        int a;
        int w;
        a = eff_addr(k, a_raw);
        w = eff_addr(k, wr_addr);
        if (a >= m_n[k]) begin
            d = 8'h00; y = 1'b1;
        end else if (m_byp[k] && wr_en && rst && w == a) begin
            d = wr_data; y = 1'b1;
        end else begin
            d = m_mem[k][a]; y = !m_pend[k][a];
        end
    endtask

    function automatic logic [7:0] model_pend(input int k);
        logic [7:0] v;
        v = '0;
        for (int i = 0; i < m_n[k]; i++) v[i] = m_pend[k][i];
        return v;
    endfunction

    task automatic model_clock();
        int w;
        int r;
        for (int k = 0; k < 3; k++) begin
            w = eff_addr(k, wr_addr);
            r = eff_addr(k, rsv_addr);
            if (wr_en && w < m_n[k]) begin
                m_mem[k][w]  = wr_data;
                m_pend[k][w] = 1'b0;
            end
            if (rsv_en && r < m_n[k]) m_pend[k][r] = 1'b1;
        end
    endtask

    task automatic model_clear();
        for (int k = 0; k < 3; k++)
            for (int i = 0; i < 8; i++) begin
                m_mem[k][i]  = 8'h00;
                m_pend[k][i] = 1'b0;
            end
    endtask

    task automatic idle_inputs();
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        rsv_en = 1'b0; rsv_addr = '0; rd_addr_a = '0; rd_addr_b = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        model_clear();
    endtask

    typedef struct {
        logic       we;
        logic [2:0] wa;
        logic [7:0] wd;
        logic       re;
        logic [2:0] ra;
        logic [2:0] rd;
        logic [7:0] ea;
        logic       eya;
        logic [7:0] ena;
        logic       enya;
        logic [3:0] ep;
    } vec_t;

    vec_t tbl [13];

    initial begin
        logic [7:0] ed;
        logic       ey;
        total_checks = 0;
        pass_checks  = 0;
        rst = 1'b0;
        idle_inputs();
        model_clear();

        //          we wa wd     re ra rd   bypass    no-bypass  pending
        tbl[0]  = '{1, 1, 8'h3C, 0, 0, 1, 8'h3C, 1, 8'h00, 1, 4'b0000};
        tbl[1]  = '{0, 0, 8'h00, 0, 0, 1, 8'h3C, 1, 8'h3C, 1, 4'b0000};
        tbl[2]  = '{0, 0, 8'h00, 1, 3, 3, 8'h00, 1, 8'h00, 1, 4'b0000};
        tbl[3]  = '{0, 0, 8'h00, 0, 0, 3, 8'h00, 0, 8'h00, 0, 4'b1000};
        tbl[4]  = '{1, 3, 8'hA5, 0, 0, 3, 8'hA5, 1, 8'h00, 0, 4'b1000};
        tbl[5]  = '{0, 0, 8'h00, 0, 0, 3, 8'hA5, 1, 8'hA5, 1, 4'b0000};
        tbl[6]  = '{1, 0, 8'h77, 1, 0, 0, 8'h77, 1, 8'h00, 1, 4'b0000};
        tbl[7]  = '{0, 0, 8'h00, 0, 0, 0, 8'h77, 0, 8'h77, 0, 4'b0001};
        tbl[8]  = '{1, 2, 8'h11, 1, 1, 2, 8'h11, 1, 8'h00, 1, 4'b0001};
        tbl[9]  = '{0, 0, 8'h00, 0, 0, 1, 8'h3C, 0, 8'h3C, 0, 4'b0011};
        tbl[10] = '{0, 0, 8'h00, 1, 2, 2, 8'h11, 1, 8'h11, 1, 4'b0011};
        tbl[11] = '{1, 2, 8'h22, 1, 1, 2, 8'h22, 1, 8'h11, 0, 4'b0111};
        tbl[12] = '{0, 0, 8'h00, 0, 0, 2, 8'h22, 1, 8'h22, 1, 4'b0011};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_data_a", da0, 8'h00);
        chk("rst_ready_a", {7'b0, ya0}, 8'h01);
        chk("rst_pending", {4'b0, p0}, 8'h00);
        @(negedge clk);
        rst = 1'b1;

        // Directed table
        for (int i = 0; i < 13; i++) begin
            wr_en = tbl[i].we; wr_addr = tbl[i].wa; wr_data = tbl[i].wd;
            rsv_en = tbl[i].re; rsv_addr = tbl[i].ra;
            rd_addr_a = tbl[i].rd; rd_addr_b = tbl[i].rd;
            #1;
            chk($sformatf("v%0d_data_a", i), da0, tbl[i].ea);
            chk($sformatf("v%0d_ready_a", i), {7'b0, ya0}, {7'b0, tbl[i].eya});
            chk($sformatf("v%0d_data_b", i), db0, tbl[i].ea);
            chk($sformatf("v%0d_ready_b", i), {7'b0, yb0}, {7'b0, tbl[i].eya});
            chk($sformatf("v%0d_nb_data_a", i), da1, tbl[i].ena);
            chk($sformatf("v%0d_nb_ready_a", i), {7'b0, ya1}, {7'b0, tbl[i].enya});
            chk($sformatf("v%0d_pending", i), {4'b0, p0}, {4'b0, tbl[i].ep});
            chk($sformatf("v%0d_nb_pending", i), {4'b0, p1}, {4'b0, tbl[i].ep});
            $display("vec %0d: wr=%0b@%0d rsv=%0b@%0d rd=%0d -> a=%0h/%0b nb=%0h/%0b pend=%b",
                     i, tbl[i].we, tbl[i].wa, tbl[i].re, tbl[i].ra, tbl[i].rd,
                     da0, ya0, da1, ya1, p0);
            @(negedge clk);
        end

        // Mid-cycle asynchronous reset discards data, reservations and the in-flight write
        idle_inputs();
        wr_en = 1'b1; wr_addr = 3'd2; wr_data = 8'h5A; rsv_en = 1'b1; rsv_addr = 3'd1;
        @(negedge clk);
        idle_inputs();
        wr_en = 1'b1; wr_addr = 3'd2; wr_data = 8'h99; rd_addr_a = 3'd2; rd_addr_b = 3'd1;
        #1;
        chk("pre_rst_nb_r2", da1, 8'h5A);
        chk("pre_rst_byp_r2", da0, 8'h99);
        #1;
        rst = 1'b0;
        #1;
        chk("async_rst_data_a", da0, 8'h00);
        chk("async_rst_ready_a", {7'b0, ya0}, 8'h01);
        chk("async_rst_ready_b", {7'b0, yb0}, 8'h01);
        chk("async_rst_pending", {4'b0, p0}, 8'h00);
        chk("async_rst_nb_data_a", da1, 8'h00);
        $display("async reset: a=%0h ready_a=%0b ready_b=%0b pending=%b", da0, ya0, yb0, p0);
        @(posedge clk);
        @(negedge clk);
        wr_en = 1'b0;
        rst = 1'b1;
        #1;
        chk("post_rst_r2", da0, 8'h00);
        chk("post_rst_nb_r2", da1, 8'h00);
        model_clear();

        // Six-register build: out-of-range write/reserve/read
        @(negedge clk);
        wr_en = 1'b1; wr_addr = 3'd7; wr_data = 8'hFF;
        rsv_en = 1'b1; rsv_addr = 3'd6; rd_addr_a = 3'd7; rd_addr_b = 3'd6;
        #1;
        chk("r6_oor_data_a", da2, 8'h00);
        chk("r6_oor_ready_a", {7'b0, ya2}, 8'h01);
        chk("r6_oor_data_b", db2, 8'h00);
        chk("r6_oor_ready_b", {7'b0, yb2}, 8'h01);
        @(negedge clk);
        idle_inputs();
        #1;
        chk("r6_oor_pending", {2'b0, p2}, 8'h00);
        for (int i = 0; i < 6; i++) begin
            rd_addr_a = 3'(i);
            #1;
            chk($sformatf("r6_unchanged_%0d", i), da2, 8'h00);
        end
        @(negedge clk);
        wr_en = 1'b1; wr_addr = 3'd4; wr_data = 8'h4D;
        @(negedge clk);
        idle_inputs();
        rd_addr_a = 3'd4; rd_addr_b = 3'd4;
        #1;
        chk("r6_r4_data_a", da2, 8'h4D);
        chk("r6_r4_data_b", db2, 8'h4D);
        chk("r6_r4_ready_b", {7'b0, yb2}, 8'h01);
        $display("six-reg: R4 a=%0h b=%0h", da2, db2);

        // Randomised traffic against the model
        do_reset();
        for (int t = 0; t < 400; t++) begin
            wr_en     = ($urandom_range(0, 2) != 0);
            wr_addr   = 3'($urandom_range(0, 7));
            wr_data   = 8'($urandom);
            rsv_en    = ($urandom_range(0, 2) == 0);
            rsv_addr  = 3'($urandom_range(0, 7));
            rd_addr_a = 3'($urandom_range(0, 7));
            rd_addr_b = ($urandom_range(0, 3) == 0) ? rd_addr_a : 3'($urandom_range(0, 7));
            #1;
            for (int k = 0; k < 3; k++) begin
                model_read(k, rd_addr_a, ed, ey);
                chk($sformatf("rnd%0d_k%0d_data_a", t, k), da[k], ed);
                chk($sformatf("rnd%0d_k%0d_ready_a", t, k), {7'b0, ya[k]}, {7'b0, ey});
                model_read(k, rd_addr_b, ed, ey);
                chk($sformatf("rnd%0d_k%0d_data_b", t, k), db[k], ed);
                chk($sformatf("rnd%0d_k%0d_ready_b", t, k), {7'b0, yb[k]}, {7'b0, ey});
                chk($sformatf("rnd%0d_k%0d_pending", t, k), po[k], model_pend(k));
            end
            $display("rnd %0d: wr=%0b@%0d=%0h rsv=%0b@%0d rdA=%0d rdB=%0d pend=%b/%b/%b",
                     t, wr_en, wr_addr, wr_data, rsv_en, rsv_addr, rd_addr_a, rd_addr_b,
                     p0, p1, p2);
            model_clock();
            @(posedge clk);
            @(negedge clk);
        end

        $display("%0d/%0d checks passed", pass_checks, total_checks);
        $finish;
    end

endmodule
